// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//   Brings up a multi-output PLL after power-up, after loss of lock and on a
//   software request. The sequencer pulses the PLL reset, waits for lock,
//   requires lock to stay stable for a while, and then releases the
//   per-domain resets one at a time. Everything runs on the reference clock.
//
// Ports
//   refclk       in   reference clock, all logic on its rising edge
//   rst          in   synchronous active-high reset
//   pll_locked   in   PLL lock indicator, asynchronous (synchronised here)
//   soft_req     in   single-cycle request to re-run the full sequence
//   pll_rst      out  reset to the PLL
//   domain_rst   out  active-high reset per PLL output domain (bit i = outclk_i)
//   ready        out  high while every domain is released
//   lock_lost    out  one-cycle pulse when lock drops after release has begun
//   retry_count  out  number of lock timeouts, saturating at 255
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int NCLK         = 3,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int STAGGER      = 8
) (
  input  logic            refclk,
  input  logic            rst,
  input  logic            pll_locked,
  input  logic            soft_req,
  output logic            pll_rst,
  output logic [NCLK-1:0] domain_rst,
  output logic            ready,
  output logic            lock_lost,
  output logic [7:0]      retry_count
);

  // One shared timer serves the pulse, timeout, filter and stagger phases,
  // so it must hold the largest terminal count of any of them.
  localparam int LAST_REL = (NCLK - 1) * STAGGER;
  localparam int MAX_A    = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int MAX_B    = (LOCK_FILTER > (LAST_REL + 1)) ? LOCK_FILTER : (LAST_REL + 1);
  localparam int TMAX     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW       = $clog2(TMAX + 1);

  localparam logic [TW-1:0]   T_ZERO   = {TW{1'b0}};
  localparam logic [TW-1:0]   T_ONE    = TW'(1);
  localparam logic [NCLK-1:0] DOM_ALL  = {NCLK{1'b1}};
  localparam logic [NCLK-1:0] DOM_NONE = {NCLK{1'b0}};

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            sync1_q;
  logic            lk_q;
  logic            pll_rst_q, pll_rst_d;
  logic [NCLK-1:0] domain_rst_q, domain_rst_d;
  logic [NCLK-1:0] rel_d;
  logic            ready_q, ready_d;
  logic            lock_lost_q, lock_lost_d;
  logic [7:0]      retry_q, retry_d;
  logic            restart_d;

  // Next-state and next-output logic of the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    rel_d       = domain_rst_q;
    restart_d   = 1'b0;

    case (state_q)
      S_RESET_PLL: begin
        // soft_req is deliberately ignored here so the pulse width is fixed.
        if (timer_q == TW'(RST_PULSE - 1)) begin
          state_d = S_WAIT_LOCK;
          timer_d = T_ZERO;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (soft_req) begin
          restart_d = 1'b1;
        end else if (lk_q) begin
          state_d = S_FILTER;
          timer_d = T_ZERO;
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          retry_d = (retry_q == 8'hFF) ? 8'hFF : (retry_q + 8'd1);
          state_d = S_RESET_PLL;
          timer_d = T_ZERO;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      S_FILTER: begin
        if (soft_req) begin
          restart_d = 1'b1;
        end else if (!lk_q) begin
          // Glitch: go back to waiting with a fresh timeout window.
          state_d = S_WAIT_LOCK;
          timer_d = T_ZERO;
        end else if (timer_q == TW'(LOCK_FILTER - 1)) begin
          state_d = S_RELEASE;
          timer_d = T_ZERO;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      S_RELEASE: begin
        if (soft_req) begin
          restart_d = 1'b1;
        end else if (!lk_q) begin
          restart_d   = 1'b1;
          lock_lost_d = 1'b1;
        end else begin
          // Bit i drops on the edge after the timer equals i*STAGGER.
          for (int i = 0; i < NCLK; i++) begin
            rel_d[i] = domain_rst_q[i] & (timer_q != TW'(i * STAGGER));
          end
          if (timer_q == TW'(LAST_REL)) begin
            state_d = S_RUN;
            timer_d = T_ZERO;
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
      end
      S_RUN: begin
        if (soft_req) begin
          restart_d = 1'b1;
        end else if (!lk_q) begin
          restart_d   = 1'b1;
          lock_lost_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        timer_d = T_ZERO;
      end
    endcase

    if (restart_d) begin
      state_d = S_RESET_PLL;
      timer_d = T_ZERO;
    end else begin
      state_d = state_d;
    end

    // Outputs are decoded from the next state so they are registered yet
    // change on the same edge as the state.
    pll_rst_d = (state_d == S_RESET_PLL);
    ready_d   = (state_d == S_RUN);
    case (state_d)
      S_RELEASE: domain_rst_d = rel_d;
      S_RUN:     domain_rst_d = DOM_NONE;
      default:   domain_rst_d = DOM_ALL;
    endcase
  end

  // State, timer, lock synchroniser and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= S_RESET_PLL;
      timer_q      <= T_ZERO;
      sync1_q      <= 1'b0;
      lk_q         <= 1'b0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= DOM_ALL;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      retry_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sync1_q      <= pll_locked;
      lk_q         <= sync1_q;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      retry_q      <= retry_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign domain_rst  = domain_rst_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//   Drives directed and random lock/soft_req/rst sequences. A phase-based
//   reference model predicts the outputs after every edge and queues them;
//   a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int NCLK         = 3;
  localparam int RST_PULSE    = 4;
  localparam int LOCK_FILTER  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int STAGGER      = 2;

  logic            refclk = 1'b0;
  logic            rst;
  logic            pll_locked;
  logic            soft_req;
  logic            pll_rst;
  logic [NCLK-1:0] domain_rst;
  logic            ready;
  logic            lock_lost;
  logic [7:0]      retry_count;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .NCLK(NCLK), .RST_PULSE(RST_PULSE), .LOCK_FILTER(LOCK_FILTER),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .STAGGER(STAGGER)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .soft_req(soft_req),
    .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready),
    .lock_lost(lock_lost), .retry_count(retry_count)
  );

  typedef struct packed {
    logic            prst;
    logic [NCLK-1:0] dom;
    logic            rdy;
    logic            lost;
    logic [7:0]      retry;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: which phase we are in and how many edges spent there.
  typedef enum int {PH_PULSE, PH_WAIT, PH_FILT, PH_REL, PH_RUN} phase_t;
  phase_t ph;
  int     cnt;
  int     retries;
  bit     lost;
  bit     samp[$];   // pll_locked as sampled at past edges (reset pushes zeros)

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit pl, input bit sr);
    bit lk;
    bit go_reset;
    if (r) begin
      ph = PH_PULSE; cnt = 0; retries = 0; lost = 1'b0;
      samp.delete(); samp.push_back(1'b0); samp.push_back(1'b0);
    end else begin
      // The FSM sees the lock value sampled two edges earlier.
      lk = samp[samp.size() - 2];
      samp.push_back(pl);
      if (samp.size() > 4) void'(samp.pop_front());
      lost = 1'b0;
      go_reset = 1'b0;
      case (ph)
        PH_PULSE: begin
          cnt++;
          if (cnt == RST_PULSE) begin ph = PH_WAIT; cnt = 0; end
        end
        PH_WAIT: begin
          if (sr) go_reset = 1'b1;
          else if (lk) begin ph = PH_FILT; cnt = 0; end
          else begin
            cnt++;
            if (cnt == LOCK_TIMEOUT) begin
              if (retries < 255) retries++;
              go_reset = 1'b1;
            end
          end
        end
        PH_FILT: begin
          if (sr) go_reset = 1'b1;
          else if (!lk) begin ph = PH_WAIT; cnt = 0; end
          else begin
            cnt++;
            if (cnt == LOCK_FILTER) begin ph = PH_REL; cnt = 0; end
          end
        end
        default: begin // PH_REL, PH_RUN
          if (sr) go_reset = 1'b1;
          else if (!lk) begin go_reset = 1'b1; lost = 1'b1; end
          else if (ph == PH_REL) begin
            cnt++;
            if (cnt > (NCLK - 1) * STAGGER) begin ph = PH_RUN; cnt = 0; end
          end
        end
      endcase
      if (go_reset) begin ph = PH_PULSE; cnt = 0; end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.prst  = (ph == PH_PULSE);
    e.rdy   = (ph == PH_RUN);
    e.lost  = lost;
    e.retry = retries[7:0];
    for (int i = 0; i < NCLK; i++) begin
      if (ph == PH_RUN)      e.dom[i] = 1'b0;
      else if (ph == PH_REL) e.dom[i] = !(i * STAGGER < cnt);
      else                   e.dom[i] = 1'b1;
    end
    return e;
  endfunction

  // Apply inputs for one edge, predict, and queue the prediction after it.
  task automatic step(input bit r, input bit pl, input bit sr);
    exp_t e;
    rst = r; pll_locked = pl; soft_req = sr;
    model_edge(r, pl, sr);
    e = model_out();
    @(posedge refclk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic hold(input bit pl, input int n);
    for (int k = 0; k < n; k++) step(1'b0, pl, 1'b0);
  endtask

  // Keep lock high until the model reaches (p, c); bounded.
  task automatic run_until(input phase_t p, input int c, input int budget);
    int n;
    n = 0;
    while (!(ph == p && cnt == c) && n < budget) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    total++;
    if (!(ph == p && cnt == c)) begin
      bad++;
      $display("FAIL reach_phase actual=%0d/%0d expected=%0d/%0d", ph, cnt, p, c);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued prediction.
  exp_t mon_e;
  always @(negedge refclk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("pll_rst",     8'(pll_rst),    8'(mon_e.prst));
      chk("domain_rst",  8'(domain_rst), 8'(mon_e.dom));
      chk("ready",       8'(ready),      8'(mon_e.rdy));
      chk("lock_lost",   8'(lock_lost),  8'(mon_e.lost));
      chk("retry_count", retry_count,    mon_e.retry);
    end
  end

  initial begin
    bit pl_r;
    rst = 1'b1; pll_locked = 1'b0; soft_req = 1'b0;
    @(posedge refclk);
    #1;

    // Reset values, then cold start with lock arriving at cycle 6.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    hold(1'b0, 6);
    hold(1'b1, 50);

    // Lock loss in RUN, then a long outage to saturate the retry counter.
    hold(1'b0, 300 * (RST_PULSE + LOCK_TIMEOUT) + 40);
    hold(1'b1, 60);

    // soft_req in RUN, then again while the PLL reset pulse is running.
    step(1'b0, 1'b1, 1'b1);
    hold(1'b1, 2);
    step(1'b0, 1'b1, 1'b1);
    hold(1'b1, 50);

    // Lock glitch of two cycles after five filtered cycles.
    step(1'b0, 1'b1, 1'b1);
    run_until(PH_FILT, 5, 100);
    hold(1'b0, 2);
    hold(1'b1, 60);

    // rst in RELEASE after domain_rst[0] has cleared.
    step(1'b0, 1'b1, 1'b1);
    run_until(PH_REL, 1, 100);
    step(1'b1, 1'b1, 1'b0);
    hold(1'b1, 40);

    // Random lock behaviour with occasional soft requests and resets.
    pl_r = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 29) == 0) pl_r = ~pl_r;
      step(($urandom_range(0, 799) == 0), pl_r, ($urandom_range(0, 79) == 0));
    end

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge refclk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
